// File: rtl/fir_pkg.sv
// Shared types and helpers for the symmetric FIR MAC.
// Optional feature macro: FIR_SATURATE_EN selects output clamping
// instead of two's-complement wrap in saturateOrTruncate().
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2,
        LOAD  = 2'd3
    } firState_t;

    // Sum of two samples needs one extra bit
    function automatic int preAddWidth(input int dataW);
        return dataW + 1;
    endfunction

    // Coefficient times pre-added sample
    function automatic int prodWidth(input int dataW, input int coefW);
        return dataW + coefW + 1;
    endfunction

    // Accumulating up to hMax products cannot overflow this width
    function automatic int accWidth(input int dataW, input int coefW, input int hMax);
        return prodWidth(dataW, coefW) + $clog2(hMax);
    endfunction

    // Address width of the coefficient store, at least one bit
    function automatic int addrWidth(input int hMax);
        return (hMax > 1) ? $clog2(hMax) : 1;
    endfunction

    // Resize a shifted accumulator to outW bits; the caller keeps the
    // low outW bits of the returned value.
    function automatic logic [63:0] saturateOrTruncate(input logic signed [63:0] val,
                                                       input int outW);
`ifdef FIR_SATURATE_EN
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        maxV = (64'sd1 <<< (outW - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (outW - 1));
        if (val > maxV) begin
            return maxV;
        end else if (val < minV) begin
            return minV;
        end else begin
            return val;
        end
`else
        return val & ((64'd1 << outW) - 64'd1);
`endif
    endfunction

endpackage

// File: rtl/fir_coeff_rf.sv
// Coefficient register file: SRAM-style write port, registered readback
// port (0 for out-of-range addresses) and an asynchronous MAC read port.
module fir_coeff_rf
    import fir_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int H_MAX  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iWrEn,
    input  logic                     iRdEn,
    input  logic [ADDR_W-1:0]        iAddr,
    input  logic signed [COEF_W-1:0] iWrDt,
    output logic signed [COEF_W-1:0] oRdDt,
    input  logic [ADDR_W-1:0]        iMacAddr,
    output logic signed [COEF_W-1:0] oMacCoef
);

    logic signed [COEF_W-1:0] coefMem [H_MAX];
    logic                     inRange;

    assign inRange  = (32'(iAddr) < H_MAX);
    assign oMacCoef = coefMem[iMacAddr];

    // Store a coefficient on an in-range write
    always_ff @(posedge iClk_12M or posedge iRst) begin
        // NOTE: the store is a small flop array, so it is cleared on reset;
        // the filter must restart with all-zero taps, not leftover values.
        if (iRst) begin
            for (int i = 0; i < H_MAX; i++) begin
                // NOTE: state is updated with <= so every flop samples the
                // values from before the edge, independent of block order.
                coefMem[i] <= '0;
            end
        end else if (iWrEn && inRange) begin
            coefMem[iAddr] <= iWrDt;
        end
    end

    // Registered readback; holds when no read is requested
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            oRdDt <= '0;
        end else if (iRdEn) begin
            oRdDt <= inRange ? coefMem[iAddr] : '0;
        end
    end

endmodule

// File: rtl/sym_fir_mac.sv
// Time-multiplexed symmetric FIR: one folded tap pair per clock through a
// single multiplier, registered product, then accumulation.
// Optional feature macro: FIR_SATURATE_EN (clamp output instead of wrap).
module sym_fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W   = 3,
    parameter int COEF_W   = 16,
    parameter int OUT_W    = 16,
    parameter int MAX_TAPS = 32,
    parameter int SHIFT    = 0
) (
    input  logic                                iClk_12M,
    input  logic                                iRst,
    input  logic                                iEnSample,
    input  logic                                iCoeffUpdateFlag,
    input  logic                                iCsnRam,
    input  logic                                iWrnRam,
    input  logic [addrWidth(MAX_TAPS/2)-1:0]    iAddrRam,
    input  logic signed [COEF_W-1:0]            iWrDtRam,
    input  logic [$clog2(MAX_TAPS):0]           iNumOfCoeff,
    input  logic signed [DATA_W-1:0]            iFirIn,
    output logic signed [OUT_W-1:0]             oFirOut,
    output logic                                oValid,
    output logic signed [COEF_W-1:0]            oRdDtRam,
    output logic                                oOverrun
);

    localparam int H_MAX  = MAX_TAPS / 2;
    localparam int ADDR_W = addrWidth(H_MAX);
    localparam int NUM_W  = $clog2(MAX_TAPS) + 1;
    localparam int IDX_W  = $clog2(MAX_TAPS);
    localparam int PRE_W  = preAddWidth(DATA_W);
    localparam int PROD_W = prodWidth(DATA_W, COEF_W);
    localparam int ACC_W  = accWidth(DATA_W, COEF_W, H_MAX);

    firState_t                state;
    logic signed [DATA_W-1:0] xDly [MAX_TAPS];
    logic [ADDR_W-1:0]        kIdx;
    logic [ADDR_W-1:0]        lastFold;
    logic [NUM_W-1:0]         nl;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;

    logic [NUM_W-1:0]         nlClamp;
    logic [NUM_W-1:0]         numFolds;
    logic [NUM_W-1:0]         mirrorIdx;
    logic signed [DATA_W-1:0] xNear;
    logic signed [DATA_W-1:0] xFar;
    logic signed [PRE_W-1:0]  preAdd;
    logic signed [COEF_W-1:0] macCoef;
    logic signed [PROD_W-1:0] prodNext;
    logic signed [ACC_W-1:0]  accSum;
    logic signed [ACC_W-1:0]  accShifted;
    logic signed [OUT_W-1:0]  outNext;
    logic                     shiftEn;
    logic                     rfWrEn;
    logic                     rfRdEn;

    // Samples are only accepted while no MAC is in flight
    assign shiftEn = iEnSample && (state == IDLE || state == LOAD);
    assign rfWrEn  = (state == LOAD) && !iCsnRam && !iWrnRam;
    assign rfRdEn  = (state == LOAD) && !iCsnRam && iWrnRam;

    fir_coeff_rf #(
        .COEF_W (COEF_W),
        .H_MAX  (H_MAX),
        .ADDR_W (ADDR_W)
    ) uCoeffRf (
        .iClk_12M (iClk_12M),
        .iRst     (iRst),
        .iWrEn    (rfWrEn),
        .iRdEn    (rfRdEn),
        .iAddr    (iAddrRam),
        .iWrDt    (iWrDtRam),
        .oRdDt    (oRdDtRam),
        .iMacAddr (kIdx),
        .oMacCoef (macCoef)
    );

    // Fold selection, pre-add, multiply and output resize
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        preAdd     = '0;
        nlClamp    = (iNumOfCoeff > NUM_W'(MAX_TAPS)) ? NUM_W'(MAX_TAPS) : iNumOfCoeff;
        numFolds   = (nlClamp + NUM_W'(1)) >> 1;
        mirrorIdx  = nl - NUM_W'(1) - NUM_W'(kIdx);
        xNear      = xDly[IDX_W'(kIdx)];
        xFar       = xDly[IDX_W'(mirrorIdx)];
        // The centre tap of an odd-length filter pairs with itself and
        // must be counted once
        if (mirrorIdx == NUM_W'(kIdx)) begin
            preAdd = PRE_W'(xNear);
        end else begin
            preAdd = PRE_W'(xNear) + PRE_W'(xFar);
        end
        prodNext   = PROD_W'(macCoef) * PROD_W'(preAdd);
        accSum     = acc + ACC_W'(prod);
        accShifted = accSum >>> SHIFT;
        outNext    = OUT_W'(saturateOrTruncate(64'(accShifted), OUT_W));
    end

    // Delay line shifts on every accepted sample
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                xDly[i] <= '0;
            end
        end else if (shiftEn) begin
            xDly[0] <= iFirIn;
            for (int i = 1; i < MAX_TAPS; i++) begin
                xDly[i] <= xDly[i-1];
            end
        end
    end

    // Sequencer: MAC folds, flush of the last product, coefficient load
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            kIdx     <= '0;
            lastFold <= '0;
            nl       <= '0;
            acc      <= '0;
            prod     <= '0;
            oFirOut  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iEnSample && (state == MAC || state == FLUSH)) begin
                oOverrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (iEnSample) begin
                        nl       <= nlClamp;
                        lastFold <= ADDR_W'(numFolds - NUM_W'(1));
                        kIdx     <= '0;
                        acc      <= '0;
                        prod     <= '0;
                        state    <= (nlClamp == '0) ? FLUSH : MAC;
                    end else if (iCoeffUpdateFlag) begin
                        state <= LOAD;
                    end
                end
                MAC: begin
                    prod <= prodNext;
                    acc  <= accSum;
                    kIdx <= kIdx + ADDR_W'(1);
                    if (kIdx == lastFold) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    acc     <= accSum;
                    oFirOut <= outNext;
                    oValid  <= 1'b1;
                    state   <= iCoeffUpdateFlag ? LOAD : IDLE;
                end
                LOAD: begin
                    if (!iCoeffUpdateFlag) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_fir_mac.sv
// Directed bench for sym_fir_mac: impulse responses, saturation/wrap,
// latency, overrun, coefficient port and asynchronous reset.
`timescale 1ns/1ps
module tb_sym_fir_mac;

    logic               iClk_12M = 1'b0;
    logic               iRst;

    // Main instance, default parameters (MAX_TAPS = 32)
    logic               iEnSample, iCoeffUpdateFlag, iCsnRam, iWrnRam;
    logic [3:0]         iAddrRam;
    logic signed [15:0] iWrDtRam;
    logic [5:0]         iNumOfCoeff;
    logic signed [2:0]  iFirIn;
    logic signed [15:0] oFirOut;
    logic               oValid;
    logic signed [15:0] oRdDtRam;
    logic               oOverrun;

    // Second instance with MAX_TAPS = 12 so out-of-range addresses exist
    logic               enS, flagS, csnS, wrnS;
    logic [2:0]         addrS;
    logic signed [15:0] wrDtS;
    logic [4:0]         numS;
    logic signed [2:0]  firInS;
    logic signed [15:0] firOutS;
    logic               validS;
    logic signed [15:0] rdDtS;
    logic               overrunS;

    int nChecks = 0;
    int nFails  = 0;
    int evenExp [7] = '{3, -6, 7, 7, -6, 3, 0};
    int oddExp  [6] = '{1, 2, 3, 2, 1, 0};

    always #42 iClk_12M = ~iClk_12M;

    sym_fir_mac dut (
        .iClk_12M         (iClk_12M),
        .iRst             (iRst),
        .iEnSample        (iEnSample),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iCsnRam          (iCsnRam),
        .iWrnRam          (iWrnRam),
        .iAddrRam         (iAddrRam),
        .iWrDtRam         (iWrDtRam),
        .iNumOfCoeff      (iNumOfCoeff),
        .iFirIn           (iFirIn),
        .oFirOut          (oFirOut),
        .oValid           (oValid),
        .oRdDtRam         (oRdDtRam),
        .oOverrun         (oOverrun)
    );

    sym_fir_mac #(.MAX_TAPS(12)) dutS (
        .iClk_12M         (iClk_12M),
        .iRst             (iRst),
        .iEnSample        (enS),
        .iCoeffUpdateFlag (flagS),
        .iCsnRam          (csnS),
        .iWrnRam          (wrnS),
        .iAddrRam         (addrS),
        .iWrDtRam         (wrDtS),
        .iNumOfCoeff      (numS),
        .iFirIn           (firInS),
        .oFirOut          (firOutS),
        .oValid           (validS),
        .oRdDtRam         (rdDtS),
        .oOverrun         (overrunS)
    );

    task automatic check(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic enterLoad();
        @(negedge iClk_12M);
        iCoeffUpdateFlag = 1'b1;
        @(posedge iClk_12M);
        @(posedge iClk_12M);
    endtask

    task automatic exitLoad();
        @(negedge iClk_12M);
        iCoeffUpdateFlag = 1'b0;
        iCsnRam          = 1'b1;
        @(posedge iClk_12M);
        @(posedge iClk_12M);
    endtask

    task automatic writeMain(input logic [3:0] addr, input logic signed [15:0] data);
        @(negedge iClk_12M);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b0;
        iAddrRam = addr;
        iWrDtRam = data;
        @(posedge iClk_12M);
        #1 iCsnRam = 1'b1;
        iWrnRam = 1'b1;
    endtask

    task automatic readMain(input logic [3:0] addr, output int val);
        @(negedge iClk_12M);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b1;
        iAddrRam = addr;
        @(posedge iClk_12M);
        #1 val = int'(oRdDtRam);
        iCsnRam = 1'b1;
    endtask

    task automatic loadMain(input logic signed [15:0] c0, c1, c2);
        enterLoad();
        writeMain(4'd0, c0);
        writeMain(4'd1, c1);
        writeMain(4'd2, c2);
        exitLoad();
    endtask

    // One strobe, then wait (bounded) for oValid; lat counts the strobe cycle
    task automatic runSample(input logic signed [2:0] x, input int n,
                             output int y, output int lat);
        y   = 0;
        lat = -1;
        @(negedge iClk_12M);
        iEnSample   = 1'b1;
        iFirIn      = x;
        iNumOfCoeff = 6'(n);
        @(posedge iClk_12M);
        #1 iEnSample = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge iClk_12M);
            #1;
            if (oValid) begin
                lat = c + 1;
                y   = int'(oFirOut);
                break;
            end
        end
    endtask

    task automatic accessS(input logic wrn, input logic [2:0] addr,
                           input logic signed [15:0] data);
        @(negedge iClk_12M);
        csnS  = 1'b0;
        wrnS  = wrn;
        addrS = addr;
        wrDtS = data;
        @(posedge iClk_12M);
        #1 csnS = 1'b1;
    endtask

    initial begin
        int y, lat, v, nValid, expSat;

        iRst = 1'b1;
        iEnSample = 1'b0; iCoeffUpdateFlag = 1'b0; iCsnRam = 1'b1; iWrnRam = 1'b1;
        iAddrRam = '0; iWrDtRam = '0; iNumOfCoeff = '0; iFirIn = '0;
        enS = 1'b0; flagS = 1'b0; csnS = 1'b1; wrnS = 1'b1;
        addrS = '0; wrDtS = '0; numS = '0; firInS = '0;

        repeat (3) @(posedge iClk_12M);
        @(negedge iClk_12M);
        check("reset oFirOut", int'(oFirOut), 0);
        check("reset oValid", int'(oValid), 0);
        check("reset oRdDtRam", int'(oRdDtRam), 0);
        check("reset oOverrun", int'(oOverrun), 0);
        iRst = 1'b0;

        // Even-length impulse, N=6
        loadMain(16'sd3, -16'sd6, 16'sd7);
        for (int i = 0; i < 7; i++) begin
            runSample((i == 0) ? 3'sd1 : 3'sd0, 6, y, lat);
            check($sformatf("even out[%0d]", i), y, evenExp[i]);
            check($sformatf("even lat[%0d]", i), lat, 5);
        end

        // Odd-length impulse, N=5
        loadMain(16'sd1, 16'sd2, 16'sd3);
        for (int i = 0; i < 6; i++) begin
            runSample((i == 0) ? 3'sd1 : 3'sd0, 5, y, lat);
            check($sformatf("odd out[%0d]", i), y, oddExp[i]);
        end
        check("odd lat", lat, 5);

        // Saturation versus wrap, N=2, constant 3: 32767*6
        loadMain(16'sh7FFF, 16'sd0, 16'sd0);
        runSample(3'sd3, 2, y, lat);
        runSample(3'sd3, 2, y, lat);
`ifdef FIR_SATURATE_EN
        expSat = 32767;
`else
        expSat = -6;
`endif
        check("sat out", y, expSat);
        check("sat lat", lat, 3);

        // N=0: no terms, zero output after two cycles
        runSample(3'sd1, 0, y, lat);
        check("n0 out", y, 0);
        check("n0 lat", lat, 2);

        // N above MAX_TAPS behaves as 32
        runSample(3'sd0, 40, y, lat);
        check("clamp lat", lat, 18);

        // Overrun: second strobe 5 cycles into a 32-tap MAC is dropped
        loadMain(16'sd1, 16'sd0, 16'sd0);
        check("overrun before", int'(oOverrun), 0);
        nValid = 0;
        lat    = -1;
        y      = 0;
        @(negedge iClk_12M);
        iEnSample = 1'b1; iFirIn = 3'sd2; iNumOfCoeff = 6'd32;
        @(posedge iClk_12M);
        #1 iEnSample = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                iEnSample = 1'b1;
                iFirIn    = 3'sd1;
            end
            @(posedge iClk_12M);
            #1 iEnSample = 1'b0;
            if (oValid) begin
                nValid++;
                if (lat < 0) begin
                    lat = c + 1;
                    y   = int'(oFirOut);
                end
            end
        end
        check("overrun flag", int'(oOverrun), 1);
        check("overrun valid count", nValid, 1);
        check("overrun lat", lat, 18);
        check("overrun out", y, 2);

        // Reset three cycles into a MAC
        @(negedge iClk_12M);
        iEnSample = 1'b1; iFirIn = 3'sd3; iNumOfCoeff = 6'd32;
        @(posedge iClk_12M);
        #1 iEnSample = 1'b0;
        repeat (3) @(posedge iClk_12M);
        #1 iRst = 1'b1;
        #5;
        check("midmac oFirOut", int'(oFirOut), 0);
        check("midmac oValid", int'(oValid), 0);
        check("midmac oOverrun", int'(oOverrun), 0);
        nValid = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 2) iRst = 1'b0;
            @(posedge iClk_12M);
            #1;
            if (oValid) nValid++;
        end
        check("midmac no valid", nValid, 0);
        enterLoad();
        readMain(4'd0, v);
        check("midmac coef cleared", v, 0);
        exitLoad();
        runSample(3'sd3, 2, y, lat);
        check("post reset out", y, 0);
        check("post reset lat", lat, 3);

        // Coefficient port on the 12-tap instance (H_MAX = 6)
        accessS(1'b0, 3'd1, 16'sh5555);     // outside LOAD: ignored
        @(negedge iClk_12M);
        flagS = 1'b1;
        @(posedge iClk_12M);
        @(posedge iClk_12M);
        accessS(1'b0, 3'd5, 16'sh01F4);
        accessS(1'b1, 3'd5, 16'sh0);
        check("rb addr5", int'(rdDtS), 500);
        accessS(1'b0, 3'd6, 16'sh1234);     // out of range: ignored
        accessS(1'b1, 3'd6, 16'sh0);
        check("rb addr6", int'(rdDtS), 0);
        accessS(1'b1, 3'd5, 16'sh0);
        check("rb addr5 again", int'(rdDtS), 500);
        accessS(1'b1, 3'd1, 16'sh0);
        check("rb idle write", int'(rdDtS), 0);
        @(negedge iClk_12M);
        flagS = 1'b0;
        @(posedge iClk_12M);
        @(posedge iClk_12M);
        accessS(1'b1, 3'd5, 16'sh0);        // outside LOAD: readback holds
        check("rb hold", int'(rdDtS), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
